// File: rtl/led_pattern_pkg.sv
// Shared mode encoding for the LED pattern generator.
package led_pattern_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_BIN_ENC     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_SCAN_ENC    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BREATHE_ENC = 2'd2;
    localparam logic [MODE_W-1:0] MODE_HOLD_ENC    = 2'd3;

    typedef enum logic [MODE_W-1:0] {
        BIN     = MODE_BIN_ENC,
        SCAN    = MODE_SCAN_ENC,
        BREATHE = MODE_BREATHE_ENC,
        HOLD    = MODE_HOLD_ENC
    } mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Divide-by-DIV prescaler: one registered tick per DIV enabled clocks.
module led_prescaler #(
    parameter int DIV = 900000
) (
    input  logic clki,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + ONE;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary count, bouncing scan, PWM breathe and hold,
// stepping once per prescaler tick.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 5,
    parameter int DIV      = 900000,
    parameter int PWM_BITS = 4
) (
    input  logic                clki,
    input  logic                rst,
    input  logic                en,
    input  logic [MODE_W-1:0]   mode,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    localparam int                  POS_W    = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

    mode_e               mode_q, mode_n;
    logic [NUM_LEDS-1:0] cnt, cnt_n, led_n;
    logic [POS_W-1:0]    pos, pos_n;
    logic                pos_up, pos_up_n;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_n, duty, duty_n;
    logic                duty_up, duty_up_n;

    led_prescaler #(.DIV(DIV)) u_prescaler (
        .clki (clki),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mode_n    = mode_q;
        cnt_n     = cnt;
        pos_n     = pos;
        pos_up_n  = pos_up;
        duty_n    = duty;
        duty_up_n = duty_up;
        pwm_n     = pwm_cnt + PWM_ONE;

        if (tick) begin
            mode_n = mode_e'(mode);
            if (mode_n != mode_q) begin
                // A mode switch only initialises the new pattern; stepping starts next tick.
                case (mode_n)
                    BIN:     cnt_n = '0;
                    SCAN:    begin pos_n  = '0; pos_up_n  = 1'b1; end
                    BREATHE: begin duty_n = '0; duty_up_n = 1'b1; end
                    default: ;
                endcase
            end else begin
                case (mode_q)
                    BIN: cnt_n = cnt + LED_ONE;
                    SCAN: begin
                        pos_n = pos_up ? pos + POS_ONE : pos - POS_ONE;
                        if (pos_n == POS_LAST)  pos_up_n = 1'b0;
                        else if (pos_n == '0)   pos_up_n = 1'b1;
                    end
                    BREATHE: begin
                        duty_n = duty_up ? duty + PWM_ONE : duty - PWM_ONE;
                        if (duty_n == DUTY_MAX) duty_up_n = 1'b0;
                        else if (duty_n == '0)  duty_up_n = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        case (mode_n)
            BIN:     led_n = cnt_n;
            SCAN:    led_n = LED_ONE << pos_n;
            BREATHE: led_n = {NUM_LEDS{pwm_n < duty_n}};
            default: led_n = led;
        endcase
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            mode_q  <= BIN;
            cnt     <= '0;
            pos     <= '0;
            pos_up  <= 1'b1;
            pwm_cnt <= '0;
            duty    <= '0;
            duty_up <= 1'b1;
            led     <= '0;
        end else if (en) begin
            mode_q  <= mode_n;
            cnt     <= cnt_n;
            pos     <= pos_n;
            pos_up  <= pos_up_n;
            pwm_cnt <= pwm_n;
            duty    <= duty_n;
            duty_up <= duty_up_n;
            led     <= led_n;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with DIV=4, NUM_LEDS=5, PWM_BITS=4.
module tb_led_pattern_gen;

    localparam int NL = 5;
    localparam int DV = 4;
    localparam int PB = 4;

    logic          clki = 1'b0;
    logic          rst  = 1'b1;
    logic          en   = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [NL-1:0] led;
    logic          tick;

    led_pattern_gen #(.NUM_LEDS(NL), .DIV(DV), .PWM_BITS(PB)) dut (
        .clki (clki),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .led  (led),
        .tick (tick)
    );

    always #5 clki = ~clki;

    typedef struct {
        logic [1:0]    mode;
        logic [NL-1:0] led;
    } vec_t;

    typedef struct {
        string         name;
        logic [NL-1:0] led;
    } exp_t;

    exp_t          sb[$];
    int            n_checks  = 0;
    int            n_pass    = 0;
    int            en_cnt    = 0;
    int            tick_cnt  = 0;
    logic          tick_prev = 1'b0;
    logic          stepped   = 1'b0;
    logic [PB-1:0] pwm_m     = '0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic expect_step(input string name, input logic [NL-1:0] v);
        exp_t e;
        e.name = name;
        e.led  = v;
        sb.push_back(e);
    endtask

    // One clock: sample just after the edge, pop the scoreboard on pattern steps,
    // and check that each tick comes exactly DV enabled cycles after the previous one.
    task automatic cyc();
        exp_t e;
        @(posedge clki);
        #1;
        stepped = tick_prev && en;
        if (en) begin
            en_cnt++;
            pwm_m++;
        end
        if (stepped && sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, int'(led), int'(e.led));
        end
        if (tick) begin
            check("tick_period", en_cnt, DV);
            en_cnt = 0;
            tick_cnt++;
        end
        tick_prev = tick;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        check("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    // Reset pulse placed strictly between two rising edges.
    task automatic pulse_rst();
        @(posedge clki);
        #2;
        rst = 1'b1;
        #1;
        check("rst_led_async", int'(led), 0);
        check("rst_tick_async", int'(tick), 0);
        rst       = 1'b0;
        en_cnt    = 0;
        tick_prev = 1'b0;
        pwm_m     = '0;
    endtask

    initial begin
        vec_t          bin_v[32];
        vec_t          scan_v[10];
        logic [NL-1:0] scan_led[10];
        logic [NL-1:0] held;
        logic [PB-1:0] duty_m;
        logic          up_m;
        int            steps;
        int            n;

        scan_led = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd8, 5'd4, 5'd2, 5'd1, 5'd2};
        for (int i = 0; i < 32; i++) begin
            bin_v[i].mode = 2'd0;
            bin_v[i].led  = NL'(i + 1);
        end
        for (int i = 0; i < 10; i++) begin
            scan_v[i].mode = 2'd1;
            scan_v[i].led  = scan_led[i];
        end

        // Reset state, before any clock edge
        #1;
        check("reset_led", int'(led), 0);
        check("reset_tick", int'(tick), 0);
        #2;
        rst = 1'b0;

        // BIN counting from reset, including wrap to 0 at tick 32
        for (int i = 0; i < 32; i++) begin
            mode = bin_v[i].mode;
            expect_step($sformatf("bin_%0d", i + 1), bin_v[i].led);
            drain(2 * DV + 2);
        end

        // SCAN from reset: switch tick gives 1, then the bounce
        pulse_rst();
        for (int i = 0; i < 10; i++) begin
            mode = scan_v[i].mode;
            expect_step($sformatf("scan_%0d", i), scan_v[i].led);
            drain(2 * DV + 2);
        end

        // Mode changes between ticks
        pulse_rst();
        mode = 2'd0;
        expect_step("bin_a", 5'd1);
        drain(2 * DV + 2);
        expect_step("bin_b", 5'd2);
        drain(2 * DV + 2);
        mode = 2'd1;
        cyc();
        mode = 2'd0;
        expect_step("glitch_ignored", 5'd3);
        drain(2 * DV + 2);
        mode = 2'd1;
        held = led;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mode_change_hold", int'(led), int'(held));
        end
        expect_step("switch_to_scan", 5'd1);
        drain(2 * DV + 2);

        // HOLD: led frozen over a switch tick plus 10 ticks
        mode     = 2'd3;
        tick_cnt = 0;
        for (int i = 0; i < 11; i++) expect_step("hold_led", 5'd1);
        drain(11 * DV + 8);
        check("hold_ticks", tick_cnt, 11);

        // en=0 freeze mid-count
        mode = 2'd0;
        expect_step("bin_reinit", 5'd0);
        drain(2 * DV + 2);
        expect_step("bin_pre_freeze", 5'd1);
        drain(2 * DV + 2);
        en   = 1'b0;
        held = led;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check("freeze_tick", int'(tick), 0);
            check("freeze_led", int'(led), int'(held));
        end
        en = 1'b1;
        expect_step("bin_resume", 5'd2);
        drain(2 * DV + 2);

        // BREATHE: per-clock PWM against a duty triangle model, up to 15 and back to 14
        mode   = 2'd2;
        duty_m = '0;
        up_m   = 1'b1;
        steps  = 0;
        n      = 0;
        while (steps < 17 && n < 200) begin
            cyc();
            n++;
            if (stepped) begin
                if (steps == 0) begin
                    duty_m = '0;
                    up_m   = 1'b1;
                end else if (up_m) begin
                    duty_m++;
                    if (duty_m == '1) up_m = 1'b0;
                end else begin
                    duty_m--;
                    if (duty_m == '0) up_m = 1'b1;
                end
                steps++;
            end
            if (steps > 0)
                check($sformatf("breathe_duty%0d_pwm%0d", duty_m, pwm_m),
                      int'(led), int'({NL{pwm_m < duty_m}}));
        end
        check("breathe_steps", steps, 17);

        // Asynchronous reset during SCAN
        mode = 2'd1;
        expect_step("scan_switch", 5'd1);
        drain(2 * DV + 2);
        expect_step("scan_step", 5'd2);
        drain(2 * DV + 2);
        pulse_rst();
        expect_step("post_rst_scan", 5'd1);
        drain(2 * DV + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The module SHALL have parameter NUM_LEDS, default 5, giving the LED count (legal range 2..16).
REQ-002 The module SHALL have parameter DIV, default 900000, giving the clock cycles per pattern tick (legal range >= 2).
REQ-003 The module SHALL have parameter PWM_BITS, default 4, giving the breathe PWM resolution (legal range 2..8).
REQ-004 clki  input  1  the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  prescaler enable; when low, all pattern state SHALL freeze.
REQ-007 mode  input  2  pattern select: 0 BIN, 1 SCAN, 2 BREATHE, 3 HOLD.
REQ-008 led  output  NUM_LEDS  LED drive, registered.
REQ-009 tick  output  1  one-cycle pulse marking a pattern step, registered.

Function
REQ-010 Prescaler: while en=1, the counter SHALL count 0..DIV-1 and wrap to 0; tick SHALL be 1 in the cycle after the counter reaches DIV-1, giving exactly one pulse per DIV enabled cycles.
REQ-011 While en=0, the prescaler, tick (held 0), the PWM counter, pattern state and led SHALL all hold.
REQ-012 mode SHALL be sampled only on a tick cycle into mode_q; a change between ticks SHALL have no effect until the next tick.
REQ-013 On a tick where mode differs from mode_q, the new mode's state SHALL be initialised: BIN cnt=0, so led=0; SCAN pos=0, dir=up, so led=1; BREATHE duty=0, dir=up; HOLD led unchanged. No step SHALL occur on that tick.
REQ-014 BIN: each tick SHALL increment the NUM_LEDS-bit cnt modulo 2^NUM_LEDS; led=cnt.
REQ-015 SCAN: led SHALL be one-hot at pos; each tick pos moves one step in dir; at pos NUM_LEDS-1 dir becomes down; at pos 0 dir becomes up. The sequence is 0,1,..,N-1,N-2,..,0,1 with a period of 2*(NUM_LEDS-1) ticks and no repeated endpoint.
REQ-016 BREATHE: a PWM_BITS free-running counter SHALL increment every enabled clock; all led bits SHALL equal (pwm_cnt < duty); each tick, duty SHALL step by 1 as a triangle between 0 and 2^PWM_BITS-1, reversing at both ends without repeating the endpoint.
REQ-017 HOLD: led and all pattern state SHALL hold; tick SHALL continue to pulse.
REQ-018 Unused led bits SHALL NOT exist: every output bit is driven in every mode.

Reset
REQ-019 rst=1 SHALL immediately clear the prescaler, pwm_cnt, cnt, pos, duty and tick to 0, and set dir to up, mode_q to BIN and led to 0, without requiring a clock edge.
REQ-020 After rst deasserts with en=1, mode=0: led SHALL become 1 after the first tick.
REQ-021 rst asserted mid-pattern SHALL discard the partial prescaler count; the first post-reset tick SHALL occur DIV enabled cycles after deassertion.

Structure
REQ-022 A package led_pattern_pkg SHALL hold the mode enum typedef (BIN, SCAN, BREATHE, HOLD) and the mode encoding constants.
REQ-023 The prescaler SHALL be a sub-module, led_prescaler, parametrised by DIV, with ports clki, rst, en and tick.
REQ-024 Counter widths SHALL be derived with $clog2 of the parameters; there SHALL be no fixed widths.

Verification (bench uses DIV=4, NUM_LEDS=5, PWM_BITS=4)
REQ-025 The bench SHALL check: reset, en=1, mode=0 -> tick every 4 cycles; led 1,2,3,... ; led=0 at tick 32 (wrap).
REQ-026 The bench SHALL check: mode=1 from reset -> switch tick led=1, then 2,4,8,16,8,4,2,1,2 on successive ticks.
REQ-027 The bench SHALL check: mode=2, after 8 ticks (duty=8) -> led=all-ones for exactly 8 of every 16 enabled clocks; duty reaches 15, then 14.
REQ-028 The bench SHALL check: mode 0->1 applied 1 cycle after a tick -> led unchanged until the next tick, then led=1; mode 3 -> led frozen over 10 ticks while tick still pulses.
REQ-029 The bench SHALL check: en=0 for 7 cycles mid-count -> no tick, led stable; tick resumes at the preserved count phase.
REQ-030 The bench SHALL check: rst pulsed between clock edges during SCAN -> led=0 before the next edge; the first tick comes 4 cycles after release.
